// File: rtl/flag_int_sequencer_if.sv
// Decoder/flag-register/interrupt bundle between the control unit and flag_int_sequencer.
// Pure wiring; the sequencer adds no latency on the decoder flag commands.
interface flag_int_sequencer_if #(
   parameter int NUM_SRC = 4
);
   localparam int VW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] IRQ;
   logic               INSTR_DONE;
   logic               SEI;
   logic               CLI;
   logic               RETI;
   logic               RETI_EN;
   logic               DEC_C_SET;
   logic               DEC_C_CLR;
   logic               DEC_C_LD;
   logic               DEC_Z_LD;

   logic               FLG_C_SET;
   logic               FLG_C_CLR;
   logic               FLG_C_LD;
   logic               FLG_Z_LD;
   logic               FLG_LD_SEL;
   logic               FLG_SHAD_LD;
   logic               I_FLAG;
   logic               INT_TAKE;
   logic [VW-1:0]      INT_VEC;
   logic               IN_ISR;

   modport master (
      output IRQ, INSTR_DONE, SEI, CLI, RETI, RETI_EN,
             DEC_C_SET, DEC_C_CLR, DEC_C_LD, DEC_Z_LD,
      input  FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
             I_FLAG, INT_TAKE, INT_VEC, IN_ISR
   );

   modport slave (
      input  IRQ, INSTR_DONE, SEI, CLI, RETI, RETI_EN,
             DEC_C_SET, DEC_C_CLR, DEC_C_LD, DEC_Z_LD,
      output FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
             I_FLAG, INT_TAKE, INT_VEC, IN_ISR
   );
endinterface

// File: rtl/flag_int_sequencer.sv
// C/Z flag + shadow sequencer around fixed-priority interrupts; decoder commands pass through with zero latency.
// ENTER and RESTORE each last one cycle; no backpressure, every input is sampled on every clock.
module flag_int_sequencer #(
   parameter int NUM_SRC     = 4,
   parameter int GUARD_INSTR = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   flag_int_sequencer_if.slave  bus
);
   localparam int VW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int GW = (GUARD_INSTR > 0) ? $clog2(GUARD_INSTR + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENTER   = 2'd1,
      S_ISR     = 2'd2,
      S_RESTORE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] irq_q, irq_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic               i_flag_q, i_flag_d;
   logic               reti_en_q, reti_en_d;
   logic [GW-1:0]      guard_q, guard_d;
   logic [VW-1:0]      vec_q, vec_d;

   logic [NUM_SRC-1:0] irq_rise;
   logic [NUM_SRC-1:0] clr_mask;
   logic [VW-1:0]      sel_idx;
   logic               take;
   logic               i_flag_cmd;

   assign irq_rise = bus.IRQ & ~irq_q;

   // Lowest index wins: scan from the top so the last hit is the smallest index.
   always_comb begin : prio_enc
      sel_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_idx = VW'(i);
         end
      end
   end

   // A fresh edge on the source being serviced re-arms it instead of being lost.
   always_comb begin : clr_dec
      clr_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         clr_mask[i] = (state_q == S_ENTER) && (vec_q == VW'(i));
      end
   end

   assign take = (state_q == S_IDLE) && bus.INSTR_DONE && i_flag_q &&
                 (|pend_q) && (guard_q == '0);

   assign i_flag_cmd = bus.CLI ? 1'b0 : (bus.SEI ? 1'b1 : i_flag_q);

   always_comb begin : next_state
      state_d   = state_q;
      irq_d     = bus.IRQ;
      pend_d    = (pend_q & ~clr_mask) | irq_rise;
      i_flag_d  = i_flag_q;
      reti_en_d = reti_en_q;
      guard_d   = guard_q;
      vec_d     = vec_q;

      if (bus.INSTR_DONE && (guard_q != '0)) begin
         guard_d = guard_q - GW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            i_flag_d = i_flag_cmd;
            if (take) begin
               state_d = S_ENTER;
               vec_d   = sel_idx;
            end
         end
         S_ENTER: begin
            i_flag_d = 1'b0;
            state_d  = S_ISR;
         end
         S_ISR: begin
            i_flag_d = i_flag_cmd;
            if (bus.RETI) begin
               reti_en_d = bus.RETI_EN;
               state_d   = S_RESTORE;
            end
         end
         S_RESTORE: begin
            i_flag_d = reti_en_q;
            guard_d  = GW'(GUARD_INSTR);
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         irq_q     <= '0;
         pend_q    <= '0;
         i_flag_q  <= 1'b0;
         reti_en_q <= 1'b0;
         guard_q   <= '0;
         vec_q     <= '0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_d;
         pend_q    <= pend_d;
         i_flag_q  <= i_flag_d;
         reti_en_q <= reti_en_d;
         guard_q   <= guard_d;
         vec_q     <= vec_d;
      end
   end

   // Outputs decode from state_q and are gated by reset so nothing leaks while RST_N is low.
   always_comb begin : outputs
      bus.FLG_C_SET   = 1'b0;
      bus.FLG_C_CLR   = 1'b0;
      bus.FLG_C_LD    = 1'b0;
      bus.FLG_Z_LD    = 1'b0;
      bus.FLG_LD_SEL  = 1'b0;
      bus.FLG_SHAD_LD = 1'b0;
      bus.INT_TAKE    = 1'b0;
      bus.IN_ISR      = 1'b0;
      bus.INT_VEC     = '0;
      bus.I_FLAG      = i_flag_q;

      if (RST_N) begin
         unique case (state_q)
            S_IDLE, S_ISR: begin
               bus.FLG_C_SET = bus.DEC_C_SET;
               bus.FLG_C_CLR = bus.DEC_C_CLR;
               bus.FLG_C_LD  = bus.DEC_C_LD;
               bus.FLG_Z_LD  = bus.DEC_Z_LD;
            end
            S_ENTER: begin
               bus.FLG_SHAD_LD = 1'b1;
               bus.INT_TAKE    = 1'b1;
            end
            S_RESTORE: begin
               bus.FLG_C_LD   = 1'b1;
               bus.FLG_Z_LD   = 1'b1;
               bus.FLG_LD_SEL = 1'b1;
            end
         endcase
         bus.IN_ISR = (state_q != S_IDLE);
         if (state_q != S_IDLE) begin
            bus.INT_VEC = vec_q;
         end
      end
   end
endmodule
